reg_bank_stream_ctrl: RTL and testbench
=======================================

# reg_bank_stream_ctrl

Command-driven streaming front end for the 8x8 register bank. Accepts load and dump commands. Load streams bytes into consecutive bank addresses through the bank's synchronous write port. Dump streams consecutive registers out through the bank's asynchronous read port, using a valid/ready output. The block sits directly upstream of the bank, is its only write master, and drives its read address.

## Interface
Parameters:
- DATA_W, 8, register width
- ADDR_W, 3, bank address width; DEPTH = 2**ADDR_W = 8

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = LOAD, 1 = DUMP
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  ADDR_W+1  beat count; legal range 1..8
- s_valid / s_ready / s_data  in/out/in  1/1/DATA_W  load byte stream
- m_valid / m_ready / m_data  out/in/out  1/1/DATA_W  dump byte stream
- rb_we  out  1  bank write enable
- rb_waddr  out  ADDR_W  bank write address
- rb_wdata  out  DATA_W  bank write data
- rb_raddr  out  ADDR_W  bank read address
- rb_rdata  in  DATA_W  bank read data, combinational from rb_raddr
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse when an illegal command is accepted

## Operation
- FSM states:
  - IDLE → LOAD on cmd_valid & !cmd_op with legal len.
  - IDLE → DUMP on cmd_valid & cmd_op with legal len.
  - LOAD → IDLE after the final beat is written.
  - DUMP → IDLE once the count is exhausted and the output register has drained.
- On command accept: ptr <= cmd_addr, rem <= cmd_len.
- Illegal len (0 or > 8): the command is still accepted (handshake completes), err=1 on the next cycle, FSM stays IDLE, no bank access.
- Address arithmetic: ptr increments modulo DEPTH; 7 wraps to 0. Length 8 from any start touches every register exactly once.
- LOAD:
  - s_ready = 1.
  - rb_we = s_valid (combinational), rb_waddr = ptr, rb_wdata = s_data.
  - Each beat: ptr++, rem--. When rem == 1 and a beat is taken, return to IDLE.
  - Outside LOAD: s_ready = 0 and rb_we = 0. Bytes offered in IDLE are neither consumed nor written.
- DUMP:
  - rb_raddr = ptr.
  - Load condition for the one-entry output register: rem != 0 & (!m_valid | m_ready).
  - On load: m_data <= rb_rdata, m_valid <= 1, ptr++, rem--.
  - When rem == 0 and m_valid & m_ready, clear m_valid and go to IDLE.
  - m_data is held stable while m_valid & !m_ready.
- rb_raddr holds its last value outside DUMP and resets to 0.

## Timing
- Reset values: cmd_ready 0 during reset then 1, s_ready 0, m_valid 0, m_data 0, rb_we 0, rb_waddr 0, rb_wdata 0, rb_raddr 0, busy 0, err 0. State is IDLE; ptr and rem are 0.
- Reset mid-LOAD or mid-DUMP aborts immediately. Bank contents are not cleared. A pending m_data beat is dropped.
- Command accepted at edge T → busy from T+1. LOAD: first write possible at edge T+2 (s_ready high in cycle T+1).
- DUMP: first m_valid at T+2 (capture at edge T+2 from rb_raddr presented in cycle T+1). Sustained 1 beat/cycle with m_ready held high. Last beat accepted → busy low the following cycle.
- cmd_ready is low from the accept edge. Back-to-back commands have at least one IDLE cycle between them.
- m_ready low stalls ptr and rem and preserves data. No beats are lost or duplicated.

## Structure
- Shared package reg_bank_pkg holds:
  - DATA_W, ADDR_W, DEPTH
  - op encoding constants OP_LOAD, OP_DUMP
  - FSM state type (IDLE, LOAD, DUMP)
- The bank module is instantiated only in the testbench/top, not inside this block.
- One sub-module is natural: reg_bank_out_reg, the one-entry valid/ready output holding register.

## Test plan
- LOAD addr=6 len=4, bytes 0xA1,0xA2,0xA3,0xA4 → bank[6]=A1, [7]=A2, [0]=A3, [1]=A4 (wrap); busy low one cycle after the 4th beat.
- DUMP addr=6 len=4 with m_ready=1 → m_data A1,A2,A3,A4 on consecutive cycles, first m_valid 2 cycles after the command accept.
- DUMP addr=0 len=8 with m_ready toggling 1,0,0,1,… → all 8 bytes in address order, each held stable while stalled, exactly 8 handshakes.
- cmd_len=0, then cmd_len=9 → err pulses one cycle each; no rb_we; busy stays 0; the next legal command works.
- Reset asserted during the 3rd LOAD beat of len=8 → next cycle all outputs at reset values; already-written bank bytes persist (verified by a subsequent DUMP).
- s_valid high in IDLE with data 0x55 → s_ready=0, rb_we=0, no bank change.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared widths, op encodings and FSM state type for the register-bank
// streaming controller.
package reg_bank_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDump
    } state_e;

    // A command may move 1..DEPTH bytes.
    function automatic logic len_legal(input logic [ADDR_W:0] len);
        return (len != '0) && (32'(len) <= DEPTH);
    endfunction

endpackage

// File: rtl/reg_bank_stream_ctrl_if.sv
// Command, load stream, dump stream and bank-port signals of the controller.
// The master modport is the controller's view; slave is its environment.
interface reg_bank_stream_ctrl_if;
    import reg_bank_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    logic              rb_we;
    logic [ADDR_W-1:0] rb_waddr;
    logic [DATA_W-1:0] rb_wdata;
    logic [ADDR_W-1:0] rb_raddr;
    logic [DATA_W-1:0] rb_rdata;

    logic              busy;
    logic              err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, s_valid, s_data, m_ready, rb_rdata,
        output cmd_ready, s_ready, m_valid, m_data, rb_we, rb_waddr, rb_wdata, rb_raddr,
        output busy, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, s_valid, s_data, m_ready, rb_rdata,
        input  cmd_ready, s_ready, m_valid, m_data, rb_we, rb_waddr, rb_wdata, rb_raddr,
        input  busy, err
    );

endinterface

// File: rtl/reg_bank_out_reg.sv
// One-entry valid/ready holding register for the dump stream; data is held
// while valid is high and ready is low.
module reg_bank_out_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [Width-1:0] data
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= din;
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/reg_bank_stream_ctrl.sv
// Command-driven front end for the 8x8 register bank: LOAD streams bytes into
// consecutive bank addresses, DUMP streams consecutive registers out.
module reg_bank_stream_ctrl
    import reg_bank_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    reg_bank_stream_ctrl_if.master       bus
);

    localparam logic [ADDR_W:0] RemOne = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] raddr_q;
    logic              accept;
    logic              out_load;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        err_d    = 1'b0;
        out_load = 1'b0;
        accept   = bus.cmd_valid && bus.cmd_ready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (len_legal(bus.cmd_len)) begin
                        ptr_d = bus.cmd_addr;
                        rem_d = bus.cmd_len;
                        unique case (bus.cmd_op)
                            OP_LOAD: state_d = StLoad;
                            OP_DUMP: state_d = StDump;
                            default: state_d = StIdle;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (bus.s_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == RemOne) state_d = StIdle;
                end
            end
            StDump: begin
                out_load = (rem_q != '0) && (!bus.m_valid || bus.m_ready);
                if (out_load) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end else if ((rem_q == '0) && bus.m_valid && bus.m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            raddr_q <= bus.rb_raddr;
        end
    end

    // Handshake outputs are gated by reset so an in-flight beat is not written.
    assign bus.cmd_ready = (state_q == StIdle) && !reset;
    assign bus.s_ready   = (state_q == StLoad) && !reset;
    assign bus.rb_we     = bus.s_ready && bus.s_valid;
    assign bus.rb_waddr  = ptr_q;
    assign bus.rb_wdata  = bus.s_ready ? bus.s_data : '0;
    assign bus.rb_raddr  = (state_q == StDump) ? ptr_q : raddr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.err       = err_q;

    reg_bank_out_reg #(
        .Width (DATA_W)
    ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .din   (bus.rb_rdata),
        .ready (bus.m_ready),
        .valid (bus.m_valid),
        .data  (bus.m_data)
    );

endmodule

// File: tb/tb_reg_bank_stream_ctrl.sv
// Bench for reg_bank_stream_ctrl: hosts the 8x8 bank and checks LOAD/DUMP
// traffic against an address-wrapping memory model.
module tb_reg_bank_stream_ctrl;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_bank_stream_ctrl_if bus ();

    reg_bank_stream_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] bank    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int checks   = 0;
    int errors   = 0;
    int we_count = 0;

    always @(posedge clk) begin
        if (bus.rb_we) begin
            bank[bus.rb_waddr] <= bus.rb_wdata;
            we_count <= we_count + 1;
        end
    end
    assign bus.rb_rdata = bank[bus.rb_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_rb_we", bus.rb_we, 0);
        check("rst_rb_waddr", bus.rb_waddr, 0);
        check("rst_rb_wdata", bus.rb_wdata, 0);
        check("rst_rb_raddr", bus.rb_raddr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
    endtask

    task automatic send_cmd(input logic op, input int addr, input int len);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = 3'(addr);
        bus.cmd_len   = 4'(len);
        #1 check("cmd_ready_idle", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1 check("cmd_ready_after", bus.cmd_ready, (len >= 1 && len <= DEPTH) ? 0 : 1);
    endtask

    task automatic do_load(input int addr, input int len, input logic [7:0] bytes [8],
                           input bit gaps);
        int start;
        send_cmd(OP_LOAD, addr, len);
        check("load_busy", bus.busy, 1);
        check("load_s_ready", bus.s_ready, 1);
        start = we_count;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = bytes[i];
            #1 check("load_we", bus.rb_we, 1);
            check("load_waddr", bus.rb_waddr, (addr + i) % DEPTH);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        #1 check("load_busy_end", bus.busy, 0);
        check("load_we_count", we_count - start, len);
        for (int i = 0; i < len; i++) ref_mem[(addr + i) % DEPTH] = bytes[i];
        for (int a = 0; a < DEPTH; a++) check("load_bank", bank[a], ref_mem[a]);
    endtask

    // mode 0: m_ready held high, 1: pattern 1,0,0,..., 2: random
    task automatic do_dump(input int addr, input int len, input int mode);
        int got = 0, cyc = 0, first = -1, last = -1;
        bit stalled = 0, rdy;
        logic [7:0] prev = '0;
        send_cmd(OP_DUMP, addr, len);
        check("dump_busy", bus.busy, 1);
        check("dump_valid_early", bus.m_valid, 0);
        while (got < len && cyc < 64) begin
            @(negedge clk);
            cyc++;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
            bus.m_ready = rdy;
            if (stalled) begin
                check("dump_hold_valid", bus.m_valid, 1);
                check("dump_hold_data", bus.m_data, prev);
            end
            if (bus.m_valid) begin
                if (first < 0) first = cyc;
                check("dump_data", bus.m_data, ref_mem[(addr + got) % DEPTH]);
                if (rdy) begin
                    got++;
                    last = cyc;
                end
            end
            stalled = bus.m_valid && !rdy;
            prev    = bus.m_data;
        end
        check("dump_first_valid", first, 1);
        check("dump_beats", got, len);
        if (mode == 0) check("dump_back_to_back", last - first, len - 1);
        @(negedge clk);
        bus.m_ready = 1'b1;
        #1 check("dump_busy_end", bus.busy, 0);
        check("dump_no_extra", bus.m_valid, 0);
        bus.m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [8];
        int start;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("rst_cmd_ready_held", bus.cmd_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs();

        // Fill every register once.
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
        do_load(0, 8, bytes, 0);

        // Wrapping load then dump.
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3; bytes[3] = 8'hA4;
        do_load(6, 4, bytes, 0);
        check("wrap_bank6", bank[6], 8'hA1);
        check("wrap_bank1", bank[1], 8'hA4);
        do_dump(6, 4, 0);
        do_dump(0, 8, 1);

        // Illegal lengths.
        start = we_count;
        send_cmd(OP_LOAD, 2, 0);
        check("err_len0", bus.err, 1);
        check("err_len0_busy", bus.busy, 0);
        @(negedge clk);
        #1 check("err_len0_pulse", bus.err, 0);
        send_cmd(OP_DUMP, 2, 9);
        check("err_len9", bus.err, 1);
        check("err_len9_busy", bus.busy, 0);
        @(negedge clk);
        #1 check("err_len9_pulse", bus.err, 0);
        check("err_no_we", we_count - start, 0);
        do_dump(3, 2, 0);

        // Bytes offered in IDLE are ignored.
        @(negedge clk);
        start       = we_count;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        #1 check("idle_s_ready", bus.s_ready, 0);
        check("idle_rb_we", bus.rb_we, 0);
        repeat (2) @(negedge clk);
        bus.s_valid = 1'b0;
        check("idle_we_count", we_count - start, 0);
        do_dump(0, 8, 2);

        // Randomized command mix.
        for (int k = 0; k < 10; k++) begin
            int op, addr, len;
            op   = $urandom_range(0, 1);
            addr = $urandom_range(0, 7);
            len  = $urandom_range(1, 8);
            if (op == 0) begin
                for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
                do_load(addr, len, bytes, 1);
            end else begin
                do_dump(addr, len, 2);
            end
        end

        // Reset during the third beat of a full load.
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
        send_cmd(OP_LOAD, 5, 8);
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = bytes[i];
            if (i == 2) begin
                reset = 1'b1;
                #1 check("midrst_cmd_ready", bus.cmd_ready, 0);
                check("midrst_rb_we", bus.rb_we, 0);
                @(negedge clk);
                reset       = 1'b0;
                bus.s_valid = 1'b0;
                #1 check_reset_outputs();
                break;
            end
            @(negedge clk);
        end
        ref_mem[5] = bytes[0];
        ref_mem[6] = bytes[1];
        do_dump(5, 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
